// File: rtl/add_sub_32_pkg.sv
// Shared width constants for the 32-bit adder/subtractor.
package add_sub_32_pkg;
  localparam int WIDTH = 32;
  localparam int GROUP = 4;
endpackage

// File: rtl/add_sub_32_cla4.sv
// 4-bit carry-lookahead group with group P/G, carry out and bit-3 carry in.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       P,
  output logic       G,
  output logic       cout,
  output logic       c3
);
  logic [3:0] p;
  logic [3:0] g;
  logic       c1;
  logic       c2;

  assign p = a ^ b;
  assign g = a & b;

  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0])
            | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1])
            | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & cin);

  assign P = &p;
  assign G = g[3] | (p[3] & g[2])
           | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);

  assign cout = G | (P & cin);
  assign s    = p ^ {c3, c2, c1, cin};
endmodule

// File: rtl/add_sub_32.sv
// 32-bit add/sub: combinational result and flags plus a registered copy.
module add_sub_32
  import add_sub_32_pkg::*;
(
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  output logic [WIDTH-1:0] ans,
  output logic             cout,
  output logic             V,
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] ans_r,
  output logic             cout_r,
  output logic             v_r
);
  localparam int NGRP = WIDTH / GROUP;

  logic [WIDTH-1:0] bx;
  logic [NGRP:0]    c;
  logic [NGRP-1:0]  gp;
  logic [NGRP-1:0]  gg;
  logic [NGRP-1:0]  gco_unused;
  logic [NGRP-1:0]  c3s;
  logic [NGRP-2:0]  c3_unused;

  assign bx   = B ^ {WIDTH{SUB}};
  assign c[0] = SUB;

  for (genvar i = 0; i < NGRP; i++) begin : g_grp
    cla4 u_cla (
      .a    (A[i*GROUP +: GROUP]),
      .b    (bx[i*GROUP +: GROUP]),
      .cin  (c[i]),
      .s    (ans[i*GROUP +: GROUP]),
      .P    (gp[i]),
      .G    (gg[i]),
      .cout (gco_unused[i]),
      .c3   (c3s[i])
    );
    // Inter-group carry from group generate/propagate.
    assign c[i+1] = gg[i] | (gp[i] & c[i]);
  end

  assign c3_unused = c3s[NGRP-2:0];
  assign cout      = c[NGRP];
  assign V         = c3s[NGRP-1] ^ c[NGRP];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ans_r  <= '0;
      cout_r <= 1'b0;
      v_r    <= 1'b0;
    end else begin
      ans_r  <= ans;
      cout_r <= cout;
      v_r    <= V;
    end
  end
endmodule

// File: tb/tb_add_sub_32.sv
// Self-checking bench: directed table, random vectors vs model, register path.
module tb_add_sub_32;
  logic [31:0] A, B;
  logic        SUB;
  logic [31:0] ans, ans_r;
  logic        cout, V, cout_r, v_r;
  logic        clk, rst_n;

  int n_cmp = 0;
  int n_bad = 0;
  time last_chg = 0;
  time max_dly = 0;

  add_sub_32 dut (
    .A(A), .B(B), .SUB(SUB),
    .ans(ans), .cout(cout), .V(V),
    .clk(clk), .rst_n(rst_n),
    .ans_r(ans_r), .cout_r(cout_r), .v_r(v_r)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(ans or cout or V) last_chg = $time;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] ans;
    logic        co;
    logic        v;
  } vec_t;

  function automatic logic [33:0] model(
    input logic [31:0] a, input logic [31:0] b, input logic s);
    int     ai, bi;
    longint sr;
    logic [32:0] u;
    logic        co, v;
    logic [31:0] r;
    ai = a;
    bi = b;
    if (s) begin
      r  = a - b;
      co = (a >= b);
      sr = longint'(ai) - longint'(bi);
    end else begin
      u  = {1'b0, a} + {1'b0, b};
      r  = u[31:0];
      co = u[32];
      sr = longint'(ai) + longint'(bi);
    end
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {r, co, v};
  endfunction

  task automatic chk(input string nm,
                     input logic [33:0] act,
                     input logic [33:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (A=%h B=%h SUB=%b)",
               nm, act, exp, A, B, SUB);
    end
  endtask

  // Apply a vector, hold 100 ns, check settle, comb and registered outputs.
  task automatic apply(input string nm, input logic [31:0] a,
                       input logic [31:0] b, input logic s,
                       input logic [33:0] exp);
    time t0, dly;
    A = a; B = b; SUB = s;
    t0 = $time;
    #100;
    dly = (last_chg >= t0) ? last_chg - t0 : 0;
    if (dly > max_dly) max_dly = dly;
    chk({nm, "_settle"}, {33'd0, dly < 100}, 34'd1);
    chk(nm, {ans, cout, V}, exp);
    chk({nm, "_reg"}, {ans_r, cout_r, v_r}, exp);
  endtask

  vec_t tbl[5];
  logic [31:0] ra, rb;
  logic        rs;

  initial begin
    tbl[0] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[2] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[3] = '{32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b0};
    tbl[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};

    rst_n = 1'b0;
    A = 32'h00000003; B = 32'h00000004; SUB = 1'b0;
    #5;
    chk("reset_regs", {ans_r, cout_r, v_r}, 34'd0);
    chk("reset_comb", {ans, cout, V}, {32'h7, 1'b0, 1'b0});

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_hold", {ans_r, cout_r, v_r}, 34'd0);

    // Registered path: one-cycle latency.
    @(negedge clk);
    A = 32'hDEADBEEF; B = 32'h21524111; SUB = 1'b0;
    @(posedge clk); #1;
    chk("reg_v1", {ans_r, cout_r, v_r},
        model(32'hDEADBEEF, 32'h21524111, 1'b0));
    @(negedge clk);
    A = 32'h00000010; B = 32'h00000020; SUB = 1'b1;
    #1;
    chk("reg_latency", {ans_r, cout_r, v_r},
        model(32'hDEADBEEF, 32'h21524111, 1'b0));
    @(posedge clk); #1;
    chk("reg_v2", {ans_r, cout_r, v_r},
        {32'hFFFFFFF0, 1'b0, 1'b0});

    // Asynchronous reset mid-cycle; comb outputs keep tracking.
    #5 rst_n = 1'b0;
    #1;
    chk("async_clr", {ans_r, cout_r, v_r}, 34'd0);
    A = 32'h7FFFFFFF; B = 32'h7FFFFFFF; SUB = 1'b0;
    #1;
    chk("comb_in_rst", {ans, cout, V}, {32'hFFFFFFFE, 1'b0, 1'b1});
    @(posedge clk); #1;
    chk("rst_hold", {ans_r, cout_r, v_r}, 34'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release", {ans_r, cout_r, v_r}, 34'd0);
    @(posedge clk); #1;
    chk("post_release", {ans_r, cout_r, v_r},
        {32'hFFFFFFFE, 1'b0, 1'b1});

    @(negedge clk);
    foreach (tbl[i])
      apply($sformatf("dir%0d", i), tbl[i].a, tbl[i].b, tbl[i].s,
            {tbl[i].ans, tbl[i].co, tbl[i].v});

    for (int i = 0; i < 5000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i % 16 == 0) rb = ra;
      if (i % 16 == 1) ra = 32'h80000000;
      if (i % 16 == 2) rb = 32'hFFFFFFFF;
      apply($sformatf("rnd%0d", i), ra, rb, rs, model(ra, rb, rs));
    end

    chk("max_settle", {33'd0, max_dly < 100}, 34'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
